fir_delay_ctrl: RTL

FIR_DELAY_CTRL -- requirements
Module: fir_delay_ctrl

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_delay_line.sv | 40 ++++
 rtl/fir_delay_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and FSM state encoding for the FIR delay/coefficient controller.
package fir_pkg;

    localparam int DEF_TAPS     = 10;
    localparam int DEF_SAMPLE_W = 3;
    localparam int DEF_COEFF_W  = 16;
    localparam int DEF_ADDR_W   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } firState_e;

    // True when a coefficient index addresses a real tap.
    function automatic logic isTapAddr(input int unsigned addr, input int unsigned taps);
        return addr < taps;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay chain: on iShift every tap takes its neighbour's value and tap 0 takes iSample.
module fir_delay_line #(
    parameter int TAPS     = fir_pkg::DEF_TAPS,
    parameter int SAMPLE_W = fir_pkg::DEF_SAMPLE_W
) (
    input  logic                     iClk12M,
    input  logic                     iRsn,
    input  logic                     iShift,
    input  logic [SAMPLE_W-1:0]      iSample,
    output logic [TAPS*SAMPLE_W-1:0] oDelay
);

    logic [SAMPLE_W-1:0] tapQ [TAPS];

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : gTap
            logic [SAMPLE_W-1:0] tapReg;
            logic [SAMPLE_W-1:0] tapNext;

            if (gi == 0) begin : gHead
                assign tapNext = iSample;
            end else begin : gBody
                assign tapNext = tapQ[gi-1];
            end

            always_ff @(posedge iClk12M or negedge iRsn) begin
                if (!iRsn) begin
                    tapReg <= '0;
                end else if (iShift) begin
                    tapReg <= tapNext;
                end
            end

            assign tapQ[gi] = tapReg;
            assign oDelay[gi*SAMPLE_W +: SAMPLE_W] = tapReg;
        end
    endgenerate

endmodule

// File: rtl/fir_delay_ctrl.sv
// FIR front-end controller: owns the sample delay chain, sequences coefficient SRAM
// reads for the MAC after each sample, and arbitrates coefficient writes while idle.
module fir_delay_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS     = DEF_TAPS,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int COEFF_W  = DEF_COEFF_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                     iClk12M,
    input  logic                     iRsn,
    input  logic                     iEnSample,
    input  logic [SAMPLE_W-1:0]      iFirIn,
    input  logic                     iCoeffWrEn,
    input  logic [ADDR_W-1:0]        iCoeffWrAddr,
    input  logic [COEFF_W-1:0]       iCoeffWrData,
    output logic                     oCoeffWrRdy,
    output logic                     oCsnRam,
    output logic                     oWrnRam,
    output logic [ADDR_W-1:0]        oAddrRam,
    output logic [COEFF_W-1:0]       oWrDtRam,
    output logic [TAPS*SAMPLE_W-1:0] oDelay,
    output logic                     oEnMul,
    output logic                     oEnAddAcc,
    output logic                     oBusy,
    output logic                     oDone,
    output logic                     oOverrun,
    output logic                     oAddrErr
);

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

    firState_e         state;
    logic [ADDR_W-1:0] tapIdx;
    logic              isIdle;
    logic              sampleAcc;
    logic              writeAcc;
    logic              addrOk;

    assign isIdle      = (state == IDLE);
    assign sampleAcc   = isIdle && iEnSample;
    assign writeAcc    = isIdle && !iEnSample && iCoeffWrEn;
    assign oCoeffWrRdy = isIdle && !iEnSample;
    assign addrOk      = isTapAddr(32'(iCoeffWrAddr), TAPS);

    fir_delay_line #(
        .TAPS     (TAPS),
        .SAMPLE_W (SAMPLE_W)
    ) uDelayLine (
        .iClk12M (iClk12M),
        .iRsn    (iRsn),
        .iShift  (sampleAcc),
        .iSample (iFirIn),
        .oDelay  (oDelay)
    );

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state     <= IDLE;
            tapIdx    <= '0;
            oCsnRam   <= 1'b1;
            oWrnRam   <= 1'b1;
            oAddrRam  <= '0;
            oWrDtRam  <= '0;
            oEnMul    <= 1'b0;
            oEnAddAcc <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oOverrun  <= 1'b0;
            oAddrErr  <= 1'b0;
        end else begin
            oDone    <= 1'b0;
            oAddrErr <= 1'b0;
            // A sample strobe is only honoured in IDLE; anywhere else it is flagged and dropped.
            oOverrun <= iEnSample && !isIdle;

            case (state)
                IDLE: begin
                    if (sampleAcc) begin
                        state    <= READ;
                        tapIdx   <= '0;
                        oCsnRam  <= 1'b0;
                        oWrnRam  <= 1'b1;
                        oAddrRam <= '0;
                        oBusy    <= 1'b1;
                    end else if (writeAcc) begin
                        state <= WRITE;
                        if (addrOk) begin
                            oCsnRam  <= 1'b0;
                            oWrnRam  <= 1'b0;
                            oAddrRam <= iCoeffWrAddr;
                            oWrDtRam <= iCoeffWrData;
                        end else begin
                            oAddrErr <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    state    <= IDLE;
                    oCsnRam  <= 1'b1;
                    oWrnRam  <= 1'b1;
                    oAddrRam <= '0;
                    oWrDtRam <= '0;
                end

                READ: begin
                    // SRAM data lags the address by one cycle, so MAC enables trail the read strobes.
                    oEnMul    <= 1'b1;
                    oEnAddAcc <= 1'b1;
                    if (tapIdx == LAST_TAP) begin
                        state    <= DRAIN;
                        oCsnRam  <= 1'b1;
                        oAddrRam <= '0;
                    end else begin
                        tapIdx   <= tapIdx + 1'b1;
                        oAddrRam <= tapIdx + 1'b1;
                    end
                end

                DRAIN: begin
                    state     <= DONE;
                    oEnMul    <= 1'b0;
                    oEnAddAcc <= 1'b0;
                    oDone     <= 1'b1;
                end

                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    oCsnRam   <= 1'b1;
                    oWrnRam   <= 1'b1;
                    oAddrRam  <= '0;
                    oWrDtRam  <= '0;
                    oEnMul    <= 1'b0;
                    oEnAddAcc <= 1'b0;
                    oBusy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
